// File: rtl/snoop_line_capture.sv
// Gathers BEATS snoop data beats into one cache line, then hands the line and its
// ring-slot BRAM address to the line writer with a level trigger held until the writer ends.
module snoop_line_capture #(
  parameter int DATA_W      = 128,
  parameter int BEATS       = 4,
  parameter int ADDR_W      = 15,
  parameter int LINE_STRIDE = 64,
  parameter int NUM_SLOTS   = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic                    i_enable,
  input  logic                    i_clr_err,
  input  logic [ADDR_W-1:0]       i_base_addr,
  input  logic [DATA_W-1:0]       i_cd_data,
  input  logic                    i_cd_valid,
  input  logic                    i_cd_last,
  output logic                    o_cd_ready,
  output logic                    o_trigger,
  input  logic                    i_wr_busy,
  input  logic                    i_wr_end,
  output logic [ADDR_W-1:0]       o_base_addr,
  output logic [BEATS*DATA_W-1:0] o_wrdata,
  output logic [3:0]              o_slot,
  output logic [15:0]             o_line_count,
  output logic                    o_err_short,
  output logic                    o_err_long,
  output logic                    o_err_timeout
);

  localparam int BEAT_IW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TIMER_W  = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_IW-1:0] LAST_BEAT = BEAT_IW'(BEATS - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);
  localparam logic [3:0]         LAST_SLOT = 4'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DRAIN,
    LAUNCH,
    WAIT_END
  } state_t;

  state_t               state_reg;
  logic [BEAT_IW-1:0]   beat_idx_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [3:0]           slot_reg;
  logic [15:0]          line_count_reg;
  logic [ADDR_W-1:0]    base_addr_reg;
  logic                 err_short_reg;
  logic                 err_long_reg;
  logic                 err_timeout_reg;
  logic [DATA_W-1:0]    beat_reg [BEATS];
  logic                 beat_accept;
  logic [ADDR_W-1:0]    slot_offset;

  assign o_cd_ready  = (state_reg == COLLECT) || (state_reg == DRAIN);
  assign o_trigger   = (state_reg == LAUNCH) || (state_reg == WAIT_END);
  assign beat_accept = i_cd_valid && o_cd_ready;
  assign slot_offset = ADDR_W'(slot_reg) * ADDR_W'(LINE_STRIDE);

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_reg       <= IDLE;
      beat_idx_reg    <= '0;
      timer_reg       <= '0;
      slot_reg        <= '0;
      line_count_reg  <= '0;
      base_addr_reg   <= '0;
      err_short_reg   <= 1'b0;
      err_long_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_enable) state_reg <= COLLECT;
        end
        COLLECT: begin
          if (beat_accept) begin
            if (beat_idx_reg == LAST_BEAT) begin
              beat_idx_reg <= '0;
              if (i_cd_last) begin
                state_reg     <= LAUNCH;
                base_addr_reg <= i_base_addr + slot_offset;
                timer_reg     <= '0;
              end else begin
                err_long_reg <= 1'b1;
                state_reg    <= DRAIN;
              end
            end else if (i_cd_last) begin
              err_short_reg <= 1'b1;
              beat_idx_reg  <= '0;
            end else begin
              beat_idx_reg <= beat_idx_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (beat_accept && i_cd_last) state_reg <= COLLECT;
        end
        LAUNCH, WAIT_END: begin
          // The timer also runs in LAUNCH so a writer that never goes busy cannot hang us.
          if ((state_reg == WAIT_END) && i_wr_end) begin
            line_count_reg <= line_count_reg + 16'd1;
            slot_reg       <= (slot_reg == LAST_SLOT) ? 4'd0 : slot_reg + 4'd1;
            beat_idx_reg   <= '0;
            state_reg      <= i_enable ? COLLECT : IDLE;
          end else if (timer_reg == TIMER_MAX) begin
            err_timeout_reg <= 1'b1;
            state_reg       <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
            if ((state_reg == LAUNCH) && i_wr_busy) state_reg <= WAIT_END;
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (i_clr_err) begin
        err_short_reg   <= 1'b0;
        err_long_reg    <= 1'b0;
        err_timeout_reg <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      logic beat_we;
      assign beat_we = (state_reg == COLLECT) && beat_accept &&
                       (beat_idx_reg == BEAT_IW'(gi));
      always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) beat_reg[gi] <= '0;
        else if (beat_we) beat_reg[gi] <= i_cd_data;
      end
      assign o_wrdata[gi*DATA_W +: DATA_W] = beat_reg[gi];
    end
  endgenerate

  assign o_base_addr   = base_addr_reg;
  assign o_slot        = slot_reg;
  assign o_line_count  = line_count_reg;
  assign o_err_short   = err_short_reg;
  assign o_err_long    = err_long_reg;
  assign o_err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_snoop_line_capture.sv
// Directed bench for snoop_line_capture: line assembly, ring addressing, framing
// errors, writer timeout and reset during a write.
module tb_snoop_line_capture;

  logic         clk = 1'b0;
  logic         srst;
  logic         enable;
  logic         clr_err;
  logic [14:0]  base;
  logic [127:0] cd_data;
  logic         cd_valid;
  logic         cd_last;
  logic         cd_ready;
  logic         trigger;
  logic         wr_busy;
  logic         wr_end;
  logic [14:0]  base_addr;
  logic [511:0] wrdata;
  logic [3:0]   slot;
  logic [15:0]  line_count;
  logic         err_short;
  logic         err_long;
  logic         err_timeout;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  snoop_line_capture dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (srst),
    .i_enable      (enable),
    .i_clr_err     (clr_err),
    .i_base_addr   (base),
    .i_cd_data     (cd_data),
    .i_cd_valid    (cd_valid),
    .i_cd_last     (cd_last),
    .o_cd_ready    (cd_ready),
    .o_trigger     (trigger),
    .i_wr_busy     (wr_busy),
    .i_wr_end      (wr_end),
    .o_base_addr   (base_addr),
    .o_wrdata      (wrdata),
    .o_slot        (slot),
    .o_line_count  (line_count),
    .o_err_short   (err_short),
    .o_err_long    (err_long),
    .o_err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic last);
    int w;
    w = 0;
    cd_data  = d;
    cd_valid = 1'b1;
    cd_last  = last;
    while (!cd_ready && w < 20) begin
      tick();
      w++;
    end
    if (!cd_ready) check("ready_wait", 512'(cd_ready), 512'd1);
    tick();
    cd_valid = 1'b0;
    cd_last  = 1'b0;
  endtask

  task automatic send_line(input logic [511:0] line);
    for (int b = 0; b < 4; b++) send_beat(line[b*128 +: 128], b == 3);
  endtask

  task automatic finish_write();
    wr_busy = 1'b1;
    tick();
    wr_end = 1'b1;
    tick();
    wr_end  = 1'b0;
    wr_busy = 1'b0;
  endtask

  function automatic logic [511:0] make_line(input int n);
    logic [511:0] l;
    for (int b = 0; b < 4; b++) l[b*128 +: 128] = {32'hC0DE0000, 32'(n), 32'(b), 32'h5A5A5A5A};
    return l;
  endfunction

  initial begin
    logic [511:0] line;
    int n;
    srst = 1'b1; enable = 1'b0; clr_err = 1'b0; base = '0;
    cd_data = '0; cd_valid = 1'b0; cd_last = 1'b0; wr_busy = 1'b0; wr_end = 1'b0;
    repeat (3) tick();
    check("rst_trigger", 512'(trigger), 512'd0);
    check("rst_ready", 512'(cd_ready), 512'd0);
    check("rst_slot", 512'(slot), 512'd0);
    check("rst_count", 512'(line_count), 512'd0);
    check("rst_errs", 512'({err_short, err_long, err_timeout}), 512'd0);
    check("rst_addr", 512'(base_addr), 512'd0);
    check("rst_wrdata", wrdata, 512'd0);
    srst = 1'b0;

    // First line A0..A3
    base = 15'h0100; enable = 1'b1;
    tick();
    check("collect_ready", 512'(cd_ready), 512'd1);
    send_beat(128'hA0A0_0000_0000_0000_0000_0000_0000_00A0, 1'b0);
    send_beat(128'hA1A1_0000_0000_0000_0000_0000_0000_00A1, 1'b0);
    send_beat(128'hA2A2_0000_0000_0000_0000_0000_0000_00A2, 1'b0);
    check("trig_before_last", 512'(trigger), 512'd0);
    send_beat(128'hA3A3_0000_0000_0000_0000_0000_0000_00A3, 1'b1);
    check("trig_latency", 512'(trigger), 512'd1);
    check("line1_data", wrdata, {128'hA3A3_0000_0000_0000_0000_0000_0000_00A3,
                                 128'hA2A2_0000_0000_0000_0000_0000_0000_00A2,
                                 128'hA1A1_0000_0000_0000_0000_0000_0000_00A1,
                                 128'hA0A0_0000_0000_0000_0000_0000_0000_00A0});
    check("line1_addr", 512'(base_addr), 512'h0100);
    check("launch_ready", 512'(cd_ready), 512'd0);
    finish_write();
    check("line1_trig_off", 512'(trigger), 512'd0);
    check("line1_count", 512'(line_count), 512'd1);
    check("line1_slot", 512'(slot), 512'd1);

    // Lines 2..17 walk the whole ring and wrap back to the base
    for (int k = 2; k <= 17; k++) begin
      line = make_line(k);
      send_line(line);
      check("ring_trig", 512'(trigger), 512'd1);
      check("ring_addr", 512'(base_addr), 512'(15'h0100 + 15'(((k - 1) % 16) * 64)));
      check("ring_data", wrdata, line);
      finish_write();
    end
    check("ring_slot", 512'(slot), 512'd1);
    check("ring_count", 512'(line_count), 512'd17);

    // Short line with clear asserted: clear wins over the set
    clr_err = 1'b1;
    send_beat(128'h51, 1'b0);
    send_beat(128'h52, 1'b1);
    clr_err = 1'b0;
    check("clr_wins", 512'(err_short), 512'd0);
    // Short line proper
    send_beat(128'h61, 1'b0);
    send_beat(128'h62, 1'b1);
    check("short_err", 512'(err_short), 512'd1);
    check("short_notrig", 512'(trigger), 512'd0);
    check("short_count", 512'(line_count), 512'd17);
    // Good line; enable dropped mid-line must not abort, but returns to IDLE at end
    line = make_line(18);
    send_beat(line[127:0], 1'b0);
    send_beat(line[255:128], 1'b0);
    enable = 1'b0;
    send_beat(line[383:256], 1'b0);
    send_beat(line[511:384], 1'b1);
    check("after_short_trig", 512'(trigger), 512'd1);
    check("after_short_addr", 512'(base_addr), 512'h0140);
    check("after_short_data", wrdata, line);
    finish_write();
    check("idle_after_end", 512'(cd_ready), 512'd0);
    check("count18", 512'(line_count), 512'd18);
    check("slot2", 512'(slot), 512'd2);
    enable = 1'b1;
    tick();
    check("reenable_ready", 512'(cd_ready), 512'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_short", 512'(err_short), 512'd0);

    // Long line: 6 beats, last on beat 5
    for (int b = 0; b < 4; b++) send_beat(128'(32'h7000 + b), 1'b0);
    check("long_err", 512'(err_long), 512'd1);
    check("drain_ready", 512'(cd_ready), 512'd1);
    send_beat(128'h7004, 1'b0);
    send_beat(128'h7005, 1'b1);
    check("long_notrig", 512'(trigger), 512'd0);
    check("long_back_collect", 512'(cd_ready), 512'd1);
    line = make_line(19);
    send_line(line);
    check("after_long_addr", 512'(base_addr), 512'h0180);
    check("after_long_data", wrdata, line);
    finish_write();
    check("count19", 512'(line_count), 512'd19);

    // Writer never ends
    line = make_line(20);
    send_line(line);
    check("to_trig", 512'(trigger), 512'd1);
    wr_busy = 1'b1;
    n = 0;
    while (trigger && n < 2000) begin
      tick();
      n++;
    end
    check("to_cycles", 512'(n), 512'd1024);
    check("to_err", 512'(err_timeout), 512'd1);
    check("to_idle", 512'(cd_ready), 512'd0);
    check("to_slot", 512'(slot), 512'd3);
    check("to_count", 512'(line_count), 512'd19);
    check("long_sticky", 512'(err_long), 512'd1);
    wr_busy = 1'b0;
    tick();

    // Reset during WAIT_END
    line = make_line(21);
    send_line(line);
    check("slot3_addr", 512'(base_addr), 512'h01C0);
    wr_busy = 1'b1;
    tick();
    srst = 1'b1;
    tick();
    check("rst_we_trig", 512'(trigger), 512'd0);
    check("rst_we_slot", 512'(slot), 512'd0);
    check("rst_we_count", 512'(line_count), 512'd0);
    check("rst_we_errs", 512'({err_short, err_long, err_timeout}), 512'd0);
    check("rst_we_wrdata", wrdata, 512'd0);
    srst = 1'b0;
    wr_busy = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
